// File: rtl/if_stage_bp.sv
// -----------------------------------------------------------------------------
// if_stage_bp : instruction-fetch stage of the 16-bit pipelined core.
//
// Owns the PC and drives the instruction-memory address. A table of 2-bit
// saturating counters predicts conditional branches at fetch time. The fetched
// instruction, its PC and the prediction are registered into the IF/ID
// boundary. The stage honours stall, flush/redirect and HALT.
//
// Ports:
//   clk              in   rising-edge clock for all state
//   reset            in   synchronous, active-high
//   stall            in   hold PC and IF/ID
//   flush            in   mispredict/redirect from execute
//   redirect_pc      in   correct next PC, valid with flush
//   update           in   resolved-branch predictor update strobe
//   update_pc        in   PC of the resolved branch
//   update_taken     in   actual branch outcome
//   imem_addr        out  instruction-memory address (= pc, combinational)
//   imem_data        in   asynchronous-read instruction at imem_addr
//   instr_ID         out  IF/ID instruction
//   pc_ID            out  PC of instr_ID
//   valid_ID         out  instr_ID is a real instruction
//   predict_taken_ID out  fetch-time prediction for instr_ID
//   halted           out  fetch frozen by HALT
// -----------------------------------------------------------------------------
module if_stage_bp #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned BHT_IDX_W = 4,
  parameter logic [3:0]  BR_OPC    = 4'hC,
  parameter logic [3:0]  HALT_OPC  = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               update,
  input  logic [PC_W-1:0]    update_pc,
  input  logic               update_taken,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_ID,
  output logic [PC_W-1:0]    pc_ID,
  output logic               valid_ID,
  output logic               predict_taken_ID,
  output logic               halted
);

  localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

  logic [PC_W-1:0]    pc_r;
  logic [1:0]         bht_r [BHT_DEPTH];

  logic               is_br_s;
  logic               is_halt_s;
  logic               pred_s;
  logic [PC_W-1:0]    next_seq_s;
  logic [1:0]         upd_ctr_s;

  logic [PC_W-1:0]    pc_nxt_s;
  logic [INSTR_W-1:0] instr_nxt_s;
  logic [PC_W-1:0]    pc_id_nxt_s;
  logic               valid_nxt_s;
  logic               pred_nxt_s;
  logic               halted_nxt_s;

  assign imem_addr = pc_r;

  // Decode the fetched word and look up the predictor (pre-update value).
  always_comb begin
    is_br_s    = (imem_data[15:12] == BR_OPC);
    is_halt_s  = (imem_data[15:12] == HALT_OPC);
    pred_s     = is_br_s & bht_r[pc_r[BHT_IDX_W-1:0]][1];
    next_seq_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  end

  // Next PC / IF/ID selection: flush > halted > stall > normal fetch.
  always_comb begin
    pc_nxt_s     = pc_r;
    instr_nxt_s  = instr_ID;
    pc_id_nxt_s  = pc_ID;
    valid_nxt_s  = valid_ID;
    pred_nxt_s   = predict_taken_ID;
    halted_nxt_s = halted;
    if (flush) begin
      pc_nxt_s     = redirect_pc;
      instr_nxt_s  = {INSTR_W{1'b0}};
      pc_id_nxt_s  = {PC_W{1'b0}};
      valid_nxt_s  = 1'b0;
      pred_nxt_s   = 1'b0;
      halted_nxt_s = 1'b0;
    end else if (halted) begin
      // Frozen: bubbles flow into IF/ID unless decode is stalling.
      if (!stall) begin
        instr_nxt_s = {INSTR_W{1'b0}};
        pc_id_nxt_s = {PC_W{1'b0}};
        valid_nxt_s = 1'b0;
        pred_nxt_s  = 1'b0;
      end else begin
        instr_nxt_s = instr_ID;
      end
    end else if (stall) begin
      pc_nxt_s = pc_r;
    end else begin
      instr_nxt_s = imem_data;
      pc_id_nxt_s = pc_r;
      valid_nxt_s = 1'b1;
      pred_nxt_s  = pred_s;
      if (is_halt_s) begin
        // HALT itself proceeds to decode; the PC stops on it.
        halted_nxt_s = 1'b1;
        pc_nxt_s     = pc_r;
      end else begin
        pc_nxt_s = pred_s ? imem_data[PC_W-1:0] : next_seq_s;
      end
    end
  end

  // PC, IF/ID boundary and halt flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r             <= {PC_W{1'b0}};
      instr_ID         <= {INSTR_W{1'b0}};
      pc_ID            <= {PC_W{1'b0}};
      valid_ID         <= 1'b0;
      predict_taken_ID <= 1'b0;
      halted           <= 1'b0;
    end else begin
      pc_r             <= pc_nxt_s;
      instr_ID         <= instr_nxt_s;
      pc_ID            <= pc_id_nxt_s;
      valid_ID         <= valid_nxt_s;
      predict_taken_ID <= pred_nxt_s;
      halted           <= halted_nxt_s;
    end
  end

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    upd_ctr_s = bht_r[update_pc[BHT_IDX_W-1:0]];
    if (update_taken) begin
      if (upd_ctr_s != 2'b11) begin
        upd_ctr_s = upd_ctr_s + 2'b01;
      end else begin
        upd_ctr_s = 2'b11;
      end
    end else begin
      if (upd_ctr_s != 2'b00) begin
        upd_ctr_s = upd_ctr_s - 2'b01;
      end else begin
        upd_ctr_s = 2'b00;
      end
    end
  end

  // Branch history table; training ignores stall, flush and halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (update) begin
      bht_r[update_pc[BHT_IDX_W-1:0]] <= upd_ctr_s;
    end
  end

endmodule

// File: tb/tb_if_stage_bp.sv
// -----------------------------------------------------------------------------
// tb_if_stage_bp : directed-vector bench for if_stage_bp. Instruction memory is
// a combinational array model; expected values are hand-computed constants.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_if_stage_bp;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [7:0]  redirect_pc;
  logic        update;
  logic [7:0]  update_pc;
  logic        update_taken;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_ID;
  logic [7:0]  pc_ID;
  logic        valid_ID;
  logic        predict_taken_ID;
  logic        halted;

  logic [15:0] imem [256];
  int          vectors;
  int          miscompares;

  if_stage_bp dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .update           (update),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .instr_ID         (instr_ID),
    .pc_ID            (pc_ID),
    .valid_ID         (valid_ID),
    .predict_taken_ID (predict_taken_ID),
    .halted           (halted)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [7:0] a);
    flush       = 1'b1;
    redirect_pc = a;
    step();
    flush       = 1'b0;
  endtask

  task automatic train(input logic taken);
    update       = 1'b1;
    update_pc    = 8'h13;
    update_taken = taken;
    step();
    update       = 1'b0;
  endtask

  // Refetch the branch at 0x13 and check prediction plus following PC.
  task automatic fetch_br(input string tag, input logic exp_pred);
    redirect(8'h13);
    step();
    check_vec({tag, "_instr"}, 32'(instr_ID), 32'h0000C020);
    check_vec({tag, "_pred"}, 32'(predict_taken_ID), 32'(exp_pred));
    check_vec({tag, "_next"}, 32'(imem_addr), exp_pred ? 32'h20 : 32'h14);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
    imem[8'h13] = 16'hC020;
    imem[8'h07] = 16'hF000;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 8'h00;
    update = 1'b0; update_pc = 8'h00; update_taken = 1'b0;

    // Reset state
    @(negedge clk);
    step();
    check_vec("rst_addr", 32'(imem_addr), 32'h0);
    check_vec("rst_instr", 32'(instr_ID), 32'h0);
    check_vec("rst_pcid", 32'(pc_ID), 32'h0);
    check_vec("rst_valid", 32'(valid_ID), 32'h0);
    check_vec("rst_pred", 32'(predict_taken_ID), 32'h0);
    check_vec("rst_halted", 32'(halted), 32'h0);
    reset = 1'b0;

    // Sequential fetch, one-cycle latency
    step();
    check_vec("seq0_instr", 32'(instr_ID), 32'h1000);
    check_vec("seq0_pcid", 32'(pc_ID), 32'h0);
    check_vec("seq0_valid", 32'(valid_ID), 32'h1);
    check_vec("seq0_addr", 32'(imem_addr), 32'h1);
    step();
    check_vec("seq1_instr", 32'(instr_ID), 32'h1001);
    check_vec("seq1_addr", 32'(imem_addr), 32'h2);
    step();
    step();
    step();
    check_vec("seq4_addr", 32'(imem_addr), 32'h5);
    check_vec("seq4_instr", 32'(instr_ID), 32'h1004);

    // Stall three cycles at pc=5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec("stall_addr", 32'(imem_addr), 32'h5);
      check_vec("stall_instr", 32'(instr_ID), 32'h1004);
      check_vec("stall_pcid", 32'(pc_ID), 32'h4);
    end
    stall = 1'b0;
    step();
    check_vec("unstall_addr", 32'(imem_addr), 32'h6);
    check_vec("unstall_instr", 32'(instr_ID), 32'h1005);
    check_vec("unstall_pcid", 32'(pc_ID), 32'h5);

    // HALT at address 7
    step();
    step();
    check_vec("halt_instr", 32'(instr_ID), 32'hF000);
    check_vec("halt_valid", 32'(valid_ID), 32'h1);
    check_vec("halt_pcid", 32'(pc_ID), 32'h7);
    check_vec("halt_flag", 32'(halted), 32'h1);
    check_vec("halt_addr", 32'(imem_addr), 32'h7);
    for (int i = 0; i < 2; i++) begin
      step();
      check_vec("halted_valid", 32'(valid_ID), 32'h0);
      check_vec("halted_instr", 32'(instr_ID), 32'h0);
      check_vec("halted_addr", 32'(imem_addr), 32'h7);
      check_vec("halted_flag", 32'(halted), 32'h1);
    end
    redirect(8'h02);
    check_vec("unhalt_flag", 32'(halted), 32'h0);
    check_vec("unhalt_addr", 32'(imem_addr), 32'h2);
    check_vec("unhalt_valid", 32'(valid_ID), 32'h0);
    step();
    check_vec("resume_instr", 32'(instr_ID), 32'h1002);
    check_vec("resume_valid", 32'(valid_ID), 32'h1);
    check_vec("resume_addr", 32'(imem_addr), 32'h3);

    // PC wraparound 0xFF -> 0x00
    redirect(8'hFF);
    check_vec("wrap_start", 32'(imem_addr), 32'hFF);
    step();
    check_vec("wrap_instr", 32'(instr_ID), 32'h10FF);
    check_vec("wrap_pcid", 32'(pc_ID), 32'hFF);
    check_vec("wrap_addr", 32'(imem_addr), 32'h0);

    // Flush overrides simultaneous stall
    stall = 1'b1;
    redirect(8'h40);
    stall = 1'b0;
    check_vec("fs_addr", 32'(imem_addr), 32'h40);
    check_vec("fs_valid", 32'(valid_ID), 32'h0);
    check_vec("fs_instr", 32'(instr_ID), 32'h0);
    check_vec("fs_pcid", 32'(pc_ID), 32'h0);

    // Predictor training on the branch at 0x13
    fetch_br("br_01", 1'b0);
    train(1'b1);
    train(1'b1);
    train(1'b1);                  // saturates at 11
    train(1'b0);                  // 10
    fetch_br("br_10", 1'b1);
    step();
    check_vec("tgt_instr", 32'(instr_ID), 32'h1020);
    check_vec("tgt_pcid", 32'(pc_ID), 32'h20);
    train(1'b0);                  // 01
    fetch_br("br_01b", 1'b0);
    train(1'b0);
    train(1'b0);
    train(1'b0);                  // saturates at 00
    train(1'b1);                  // 01
    // Same-cycle lookup and update: lookup sees 01, counter becomes 10
    redirect(8'h13);
    update = 1'b1; update_pc = 8'h13; update_taken = 1'b1;
    step();
    update = 1'b0;
    check_vec("same_pred", 32'(predict_taken_ID), 32'h0);
    check_vec("same_next", 32'(imem_addr), 32'h14);
    fetch_br("br_after", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage_bp.md
Name: if_stage_bp

Overview:
- Instruction-fetch stage of the 16-bit pipelined core. Owns the 8-bit PC and drives instruction-memory address.
- Predicts conditional branches with a table of 2-bit saturating counters.
- Registers fetched instruction, PC and prediction into the IF/ID boundary consumed by decode/control. Honours stall, flush/redirect and HALT.

Parameters:
- PC_W, 8, PC and address width.
- INSTR_W, 16, instruction width.
- BHT_IDX_W, 4, predictor index bits (table depth = 2^BHT_IDX_W), indexed by pc[BHT_IDX_W-1:0].
- BR_OPC, 4'hC, opcode (instr[15:12]) of a conditional branch; absolute target is instr[7:0].
- HALT_OPC, 4'hF, opcode of HALT.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and IF/ID.
- flush  in  1  mispredict/redirect from execute.
- redirect_pc  in  PC_W  correct next PC, valid with flush.
- update  in  1  resolved-branch predictor update strobe.
- update_pc  in  PC_W  PC of resolved branch.
- update_taken  in  1  actual outcome.
- imem_addr  out  PC_W  = pc (combinational).
- imem_data  in  INSTR_W  asynchronous-read instruction at imem_addr.
- instr_ID  out  INSTR_W  IF/ID instruction.
- pc_ID  out  PC_W  PC of instr_ID.
- valid_ID  out  1  instr_ID is real.
- predict_taken_ID  out  1  fetch-time prediction for instr_ID.
- halted  out  1  fetch frozen by HALT.

Behaviour:
- Reset (sync, active-high): pc=0, instr_ID=16'h0000 (NOP), pc_ID=0, valid_ID=0, predict_taken_ID=0, halted=0, every BHT counter=2'b01 (weakly not-taken).
- Per-cycle priority: reset > flush > halted > stall > normal fetch.
- is_br = imem_data[15:12]==BR_OPC.
- pred = is_br & bht[pc[BHT_IDX_W-1:0]][1].
- next_seq = pc+1, modulo 2^PC_W (8'hFF -> 8'h00).
- Normal fetch (not stalled, not halted):
  - pc <= pred ? imem_data[7:0] : next_seq.
  - instr_ID <= imem_data; pc_ID <= pc; valid_ID <= 1; predict_taken_ID <= pred.
  - Latency: instruction at address A appears on instr_ID one cycle after imem_addr==A.
- Stall: pc and all IF/ID outputs hold their values.
- Flush:
  - pc <= redirect_pc; IF/ID cleared to NOP (instr 0, valid 0, pred 0, pc_ID 0); halted <= 0.
  - Flush overrides simultaneous stall and halted.
- HALT:
  - When a normal fetch captures opcode HALT_OPC, the HALT enters IF/ID as a valid instruction, halted <= 1, and pc holds.
  - While halted and no flush: pc holds; IF/ID loads NOP/valid 0 each non-stalled cycle; under stall IF/ID holds.
  - A HALT fetched during stall is not captured (stall wins).
- Predictor update:
  - On update, bht[update_pc idx] increments (taken) or decrements (not-taken), saturating at 2'b11 / 2'b00.
  - Update is independent of stall, flush and halted; blocked only by reset.
- Same-cycle read/write of one BHT entry: the lookup uses the pre-update value; the new value is visible next cycle.
- Aliasing: PCs sharing low BHT_IDX_W bits share a counter, by design.

Test Plan:
- Reset, imem[i]=16'h1000+i, no stall -> imem_addr 0,1,2,…; instr_ID 16'h1000 with pc_ID 0 and valid_ID 1 one cycle after reset release.
- pc=8'hFF, sequential instruction -> next imem_addr 8'h00.
- Stall asserted 3 cycles at pc=5 -> imem_addr stays 5; instr_ID/pc_ID unchanged; resumes with pc=6 on release.
- Flush with redirect_pc=8'h40 and stall asserted the same cycle -> next imem_addr 8'h40; valid_ID 0, instr_ID 16'h0000.
- Predictor training:
  - imem[8'h13]=16'hC020 with counter at 01 -> predict_taken_ID 0, next pc 8'h14.
  - Then two update (pc 8'h13, taken=1) pulses -> counter 11; third taken pulse stays 11.
  - Refetch of 8'h13 -> predict_taken_ID 1, next pc 8'h20.
  - Three not-taken updates -> 00, fourth stays 00.
- imem[7]=16'hF000 -> HALT latched with valid_ID 1; halted 1; pc stuck at 7; following cycles valid_ID 0. Then flush with redirect_pc=8'h02 -> halted 0, fetch resumes at 2.
